// File: rtl/banked_data_memory.sv
// Banked data memory: address and bank registers, combinational read, clocked write, sticky collision flag.
// Build macro MBS_BANKING_EN enables four banks; without it a single bank is used and the bank inputs are ignored.
module banked_data_memory #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 16
) (
   input  logic                  in_clk,
   input  logic                  in_reset,
   input  logic [DATA_WIDTH-1:0] in_bus,
   input  logic                  in_addr_wr_enable,
   input  logic                  in_read_enable,
   input  logic                  in_wr_enable,
   input  logic                  in_mbs_wr_enable,
   input  logic [1:0]            in_mbs_value,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_data_valid,
   output logic [ADDR_WIDTH-1:0] out_addr,
   output logic [1:0]            out_bank,
   output logic                  out_error
);

   // Access rules: a read alone drives the word this cycle; a write alone
   // commits at the edge; read and write together is a collision that
   // blocks the write and latches out_error until reset.
`ifdef MBS_BANKING_EN
   localparam int IDX_BITS = ADDR_WIDTH + 2;
`else
   localparam int IDX_BITS = ADDR_WIDTH;
`endif
   localparam int DEPTH = 1 << IDX_BITS;

   logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];
   logic [ADDR_WIDTH-1:0] addr;
   logic [1:0]            bank;
   logic                  error;
   logic [IDX_BITS-1:0]   idx;
   logic                  read_ok;
   logic                  do_write;
   logic                  collision;

`ifdef MBS_BANKING_EN
   assign idx = {bank, addr};

   always_ff @(posedge in_clk or posedge in_reset) begin
      if (in_reset) begin
         bank <= 2'b00;
      end else if (in_mbs_wr_enable) begin
         bank <= in_mbs_value;
      end
   end
`else
   logic unused_bank_inputs;

   assign idx                = addr;
   assign bank               = 2'b00;
   assign unused_bank_inputs = &{1'b0, in_mbs_wr_enable, in_mbs_value};
`endif

   assign read_ok   = in_read_enable & ~in_wr_enable & ~in_reset;
   assign do_write  = in_wr_enable & ~in_read_enable & ~in_reset;
   assign collision = in_read_enable & in_wr_enable;

   // Address and flag use pre-edge values for the access; indirect
   // addressing falls out of loading addr while the old word is read.
   always_ff @(posedge in_clk or posedge in_reset) begin
      if (in_reset) begin
         addr  <= '0;
         error <= 1'b0;
      end else begin
         if (in_addr_wr_enable) begin
            addr <= in_bus[ADDR_WIDTH-1:0];
         end
         if (collision) begin
            error <= 1'b1;
         end
      end
   end

   // Array has no reset so contents survive in_reset.
   always_ff @(posedge in_clk) begin
      if (do_write) begin
         mem[idx] <= in_bus;
      end
   end

   assign out_data       = read_ok ? mem[idx] : '0;
   assign out_data_valid = read_ok;
   assign out_addr       = addr;
   assign out_bank       = bank;
   assign out_error      = error;

endmodule

// File: tb/tb_banked_data_memory.sv
// Self-checking bench for banked_data_memory: scenario tasks with a reference model and read scoreboard.
// Expectations follow MBS_BANKING_EN the same way the design build does.
module tb_banked_data_memory;

   logic        clk;
   logic        rst;
   logic [15:0] bus;
   logic        aw, rd, wr, mw;
   logic [1:0]  mv;
   logic [15:0] out_data;
   logic        out_data_valid;
   logic [7:0]  out_addr;
   logic [1:0]  out_bank;
   logic        out_error;

   int total = 0;
   int bad   = 0;

   logic [15:0] exp_q[$];
   logic [15:0] m_mem [0:1023];
   logic [7:0]  m_addr;
   logic [1:0]  m_bank;
   logic        m_err;
   logic [15:0] exp_v;

   banked_data_memory #(.ADDR_WIDTH(8), .DATA_WIDTH(16)) dut (
      .in_clk            (clk),
      .in_reset          (rst),
      .in_bus            (bus),
      .in_addr_wr_enable (aw),
      .in_read_enable    (rd),
      .in_wr_enable      (wr),
      .in_mbs_wr_enable  (mw),
      .in_mbs_value      (mv),
      .out_data          (out_data),
      .out_data_valid    (out_data_valid),
      .out_addr          (out_addr),
      .out_bank          (out_bank),
      .out_error         (out_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int m_idx();
`ifdef MBS_BANKING_EN
      return int'({m_bank, m_addr});
`else
      return int'(m_addr);
`endif
   endfunction

   task automatic model_reset();
      m_addr = 8'h00;
      m_bank = 2'b00;
      m_err  = 1'b0;
   endtask

   // Drive one cycle's inputs at the falling edge; queue the expected read word.
   task automatic set_in(input logic a_aw, input logic a_rd, input logic a_wr,
                         input logic a_mw, input logic [1:0] a_mv, input logic [15:0] a_bus);
      @(negedge clk);
      aw = a_aw; rd = a_rd; wr = a_wr; mw = a_mw; mv = a_mv; bus = a_bus;
      if (a_rd) exp_q.push_back((!a_wr && !rst) ? m_mem[m_idx()] : 16'h0000);
   endtask

   task automatic tick();
      @(posedge clk);
      if (!rst) begin
         if (wr && !rd) m_mem[m_idx()] = bus;
         if (rd && wr) m_err = 1'b1;
         if (aw) m_addr = bus[7:0];
`ifdef MBS_BANKING_EN
         if (mw) m_bank = mv;
`endif
      end
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      model_reset();
      set_in(1'b1, 1'b1, 1'b0, 1'b1, 2'd3, 16'h00AB);
      #1;
      total++; exp_v = exp_q.pop_front();
      if (out_data !== exp_v) begin bad++; $display("FAIL reset_data: got %h exp %h", out_data, exp_v); end
      total++; if (out_data_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b exp 0", out_data_valid); end
      tick();
      total++; if (out_addr !== 8'h00) begin bad++; $display("FAIL reset_addr: got %h exp 00", out_addr); end
      total++; if (out_bank !== 2'd0) begin bad++; $display("FAIL reset_bank: got %0d exp 0", out_bank); end
      total++; if (out_error !== 1'b0) begin bad++; $display("FAIL reset_error: got %b exp 0", out_error); end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_basic();
      set_in(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0042); tick();
      set_in(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 16'hBEEF); tick();
      set_in(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 16'h0000); #1;
      total++; if (out_addr !== 8'h42) begin bad++; $display("FAIL basic_addr: got %h exp 42", out_addr); end
      total++; exp_v = exp_q.pop_front();
      if (out_data !== exp_v || exp_v !== 16'hBEEF) begin bad++; $display("FAIL basic_data: got %h exp BEEF", out_data); end
      total++; if (out_data_valid !== 1'b1) begin bad++; $display("FAIL basic_valid: got %b exp 1", out_data_valid); end
      tick();
   endtask

   task automatic test_indirect();
      set_in(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0010); tick();
      set_in(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 16'h0033); tick();
      set_in(1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 16'h0033); #1;
      total++; exp_v = exp_q.pop_front();
      if (out_data !== exp_v) begin bad++; $display("FAIL indirect_data: got %h exp %h", out_data, exp_v); end
      tick();
      total++; if (out_addr !== 8'h33) begin bad++; $display("FAIL indirect_addr: got %h exp 33", out_addr); end
   endtask

   task automatic test_banks();
      set_in(1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 16'h0005); tick();
      set_in(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 16'h1111); tick();
      set_in(1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 16'h0000); tick();
      set_in(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 16'h3333); tick();
      total++;
`ifdef MBS_BANKING_EN
      if (out_bank !== 2'd3) begin bad++; $display("FAIL bank_reg: got %0d exp 3", out_bank); end
`else
      if (out_bank !== 2'd0) begin bad++; $display("FAIL bank_reg: got %0d exp 0", out_bank); end
`endif
      set_in(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 16'h0000); #1;
      total++; exp_v = exp_q.pop_front();
      if (out_data !== exp_v || exp_v !== 16'h3333) begin bad++; $display("FAIL bank3_data: got %h exp 3333", out_data); end
      tick();
      set_in(1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 16'h0000); tick();
      set_in(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 16'h0000); #1;
      total++; exp_v = exp_q.pop_front();
      if (out_data !== exp_v) begin bad++; $display("FAIL bank0_data: got %h exp %h", out_data, exp_v); end
      tick();
   endtask

   task automatic test_collision();
      set_in(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0007); tick();
      set_in(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 16'h5555); tick();
      set_in(1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 16'hAAAA); #1;
      total++; exp_v = exp_q.pop_front();
      if (out_data !== exp_v || exp_v !== 16'h0000) begin bad++; $display("FAIL coll_data: got %h exp 0000", out_data); end
      total++; if (out_data_valid !== 1'b0) begin bad++; $display("FAIL coll_valid: got %b exp 0", out_data_valid); end
      tick();
      total++; if (out_error !== 1'b1) begin bad++; $display("FAIL coll_error: got %b exp 1", out_error); end
      set_in(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0000); tick();
      total++; if (out_error !== 1'b1) begin bad++; $display("FAIL coll_sticky: got %b exp 1", out_error); end
      set_in(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 16'h0000); #1;
      total++; exp_v = exp_q.pop_front();
      if (out_data !== exp_v || exp_v !== 16'h5555) begin bad++; $display("FAIL coll_keep: got %h exp 5555", out_data); end
      tick();
   endtask

   task automatic test_async_reset();
      set_in(1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 16'h007F); tick();
      set_in(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 16'h1234); tick();
      set_in(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 16'hDEAD);
      #2 rst = 1'b1;
      model_reset();
      #1;
      total++; if (out_addr !== 8'h00) begin bad++; $display("FAIL areset_addr: got %h exp 00", out_addr); end
      total++; if (out_bank !== 2'd0) begin bad++; $display("FAIL areset_bank: got %0d exp 0", out_bank); end
      total++; if (out_error !== 1'b0) begin bad++; $display("FAIL areset_error: got %b exp 0", out_error); end
      tick();
      @(negedge clk);
      rst = 1'b0;
      set_in(1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 16'h007F); tick();
      set_in(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 16'h0000); #1;
      total++; exp_v = exp_q.pop_front();
      if (out_data !== exp_v || exp_v !== 16'h1234) begin bad++; $display("FAIL areset_keep: got %h exp 1234", out_data); end
      tick();
   endtask

   task automatic test_addr_trunc();
      set_in(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 16'h01FF); tick();
      total++; if (out_addr !== 8'hFF) begin bad++; $display("FAIL trunc_addr: got %h exp FF", out_addr); end
      set_in(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 16'hCAFE); tick();
      set_in(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 16'h0000); #1;
      total++; exp_v = exp_q.pop_front();
      if (out_data !== exp_v || exp_v !== 16'hCAFE) begin bad++; $display("FAIL trunc_data: got %h exp CAFE", out_data); end
      tick();
   endtask

   task automatic test_back_to_back();
      logic a_aw, a_rd, a_wr, a_mw;
      logic [15:0] a_bus;
      for (int b = 0; b < 4; b++) begin
         for (int a = 0; a < 4; a++) begin
            set_in(1'b1, 1'b0, 1'b0, 1'b1, 2'(b), 16'(a)); tick();
            set_in(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 16'($urandom_range(0, 65535))); tick();
         end
      end
      for (int i = 0; i < 60; i++) begin
         a_aw  = ($urandom_range(0, 3) == 0);
         a_rd  = ($urandom_range(0, 1) == 1);
         a_wr  = ($urandom_range(0, 3) == 0);
         a_mw  = ($urandom_range(0, 3) == 0);
         a_bus = a_aw ? 16'($urandom_range(0, 3)) : 16'($urandom_range(0, 65535));
         set_in(a_aw, a_rd, a_wr, a_mw, 2'($urandom_range(0, 3)), a_bus);
         #1;
         if (a_rd) begin
            total++; exp_v = exp_q.pop_front();
            if (out_data !== exp_v) begin bad++; $display("FAIL b2b_data[%0d]: got %h exp %h", i, out_data, exp_v); end
         end
         total++;
         if (out_data_valid !== (a_rd && !a_wr)) begin bad++; $display("FAIL b2b_valid[%0d]: got %b exp %b", i, out_data_valid, a_rd && !a_wr); end
         tick();
         total++;
         if (out_addr !== m_addr || out_bank !== m_bank || out_error !== m_err) begin
            bad++;
            $display("FAIL b2b_regs[%0d]: got a=%h b=%0d e=%b exp a=%h b=%0d e=%b",
                     i, out_addr, out_bank, out_error, m_addr, m_bank, m_err);
         end
      end
   endtask

   initial begin
      rst = 1'b1; bus = '0; aw = 1'b0; rd = 1'b0; wr = 1'b0; mw = 1'b0; mv = 2'd0;
      for (int i = 0; i < 1024; i++) m_mem[i] = 16'h0000;
      model_reset();
      test_reset();
      test_basic();
      test_indirect();
      test_banks();
      test_collision();
      test_async_reset();
      test_addr_trunc();
      test_back_to_back();
      total++;
      if (exp_q.size() != 0) begin bad++; $display("FAIL queue_drain: got %0d left exp 0", exp_q.size()); end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
